// File: rtl/color_fsm_ctrl.sv
// Blue/Red/Green colour controller with min-dwell gating, Green timeout and saturating Red residency count.
// Define COLOR_FSM_STAT_EN to add the trans_cnt and timeout_o statistics ports.
module color_fsm_ctrl #(
  parameter int OUT_WIDTH = 2,
  parameter int OUT_BLUE  = 1,
  parameter int OUT_RED   = 2,
  parameter int OUT_GREEN = 3,
  parameter int CNT_WIDTH = 8,
  parameter int DWELL_MIN = 2,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [1:0]           cmd,
  input  logic                 cnt_clr,
  output logic [OUT_WIDTH-1:0] out,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] dwell_cnt,
  output logic [CNT_WIDTH-1:0] red_cnt
`ifdef COLOR_FSM_STAT_EN
  ,
  output logic [CNT_WIDTH-1:0] trans_cnt,
  output logic                 timeout_o
`endif
);

  typedef enum logic [1:0] {
    BLUE  = 2'd0,
    RED   = 2'd1,
    GREEN = 2'd2,
    BAD   = 2'd3
  } state_t;

  localparam logic [1:0] CMD_NEXT = 2'd1;
  localparam logic [1:0] CMD_BACK = 2'd2;
  localparam logic [1:0] CMD_HOME = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] DMIN    = CNT_WIDTH'(DWELL_MIN);
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam bit                   TO_EN   = (TIMEOUT != 0);

  localparam logic [OUT_WIDTH-1:0] CODE_BLUE  = OUT_WIDTH'(OUT_BLUE);
  localparam logic [OUT_WIDTH-1:0] CODE_RED   = OUT_WIDTH'(OUT_RED);
  localparam logic [OUT_WIDTH-1:0] CODE_GREEN = OUT_WIDTH'(OUT_GREEN);

  state_t state;
  state_t state_nxt;
  logic   chg;
  logic   to_hit;
  logic   dwell_ok;

  // Every non-hold branch lands in a different state, except HOME in Red, which still counts as a change.
  always_comb begin
    state_nxt = state;
    chg       = 1'b0;
    to_hit    = 1'b0;
    dwell_ok  = (DWELL_MIN == 0) || (dwell_cnt >= DMIN);
    if (cmd == CMD_HOME) begin
      state_nxt = RED;
      chg       = 1'b1;
    end else if (state == BAD) begin
      state_nxt = RED;
      chg       = 1'b1;
    end else if (TO_EN && state == GREEN && dwell_cnt == TO_LAST) begin
      state_nxt = RED;
      chg       = 1'b1;
      to_hit    = 1'b1;
    end else if (dwell_ok && cmd == CMD_NEXT) begin
      chg = 1'b1;
      case (state)
        BLUE:    state_nxt = RED;
        RED:     state_nxt = GREEN;
        default: state_nxt = BLUE;
      endcase
    end else if (dwell_ok && cmd == CMD_BACK) begin
      chg = 1'b1;
      case (state)
        BLUE:    state_nxt = GREEN;
        RED:     state_nxt = BLUE;
        default: state_nxt = RED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RED;
      dwell_cnt <= '0;
      red_cnt   <= '0;
    end else if (en) begin
      state <= state_nxt;
      if (chg)
        dwell_cnt <= '0;
      else if (dwell_cnt != CNT_MAX)
        dwell_cnt <= dwell_cnt + 1'b1;
      if (cnt_clr)
        red_cnt <= '0;
      else if (state == RED && red_cnt != CNT_MAX)
        red_cnt <= red_cnt + 1'b1;
    end
  end

`ifdef COLOR_FSM_STAT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trans_cnt <= '0;
      timeout_o <= 1'b0;
    end else if (en) begin
      if (chg)
        trans_cnt <= trans_cnt + 1'b1;
      timeout_o <= to_hit;
    end
  end
`endif

  always_comb begin
    case (state)
      BLUE:    out = CODE_BLUE;
      GREEN:   out = CODE_GREEN;
      default: out = CODE_RED;
    endcase
  end

  assign state_o = state;

endmodule
